wb_port_arbiter: RTL and testbench

- Owns the register file's single write port.
- Shares the port between two requesters:
  - the in-order pipeline writeback, whose destination comes from the 5-bit rt/rd select;
  - a late-result unit (multi-cycle MUL/DIV, or a load that missed).
- Late results are buffered in a small FIFO and drained into idle pipeline slots. A starvation counter stalls the pipeline when a late result has waited too long.
- Sits between the WB stage / late unit and the regfile write inputs.

---
 rtl/wb_port_arbiter_pkg.sv | 27 ++
 rtl/wb_lu_fifo.sv | 90 +++++++++
 rtl/wb_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter_pkg
//   Shared types and constants for the regfile write-port arbiter.
//   - DEFAULT_DATA_W / DEFAULT_ADDR_W : default datapath widths
//   - REG_ZERO                        : hard-wired zero register address
//   - arb_state_e                     : normal / forced-drain arbitration state
//   - gnt_src_e                       : which requester owns the port this cycle
//   Optional statistics are enabled by defining WB_ARB_STATS_EN (off by default).
// ---------------------------------------------------------------------------
package wb_port_arbiter_pkg;

    localparam int unsigned DEFAULT_DATA_W = 32;
    localparam int unsigned DEFAULT_ADDR_W = 5;
    localparam logic [4:0]  REG_ZERO       = 5'd0;

    typedef enum logic {
        ARB_NORMAL = 1'b0,
        ARB_FORCE  = 1'b1
    } arb_state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_PIPE = 2'd1,
        GNT_HEAD = 2'd2
    } gnt_src_e;

endpackage

// File: rtl/wb_lu_fifo.sv
// ---------------------------------------------------------------------------
// wb_lu_fifo
//   Late-result buffer: DEPTH-entry circular FIFO of {addr, data}.
//   Ports:
//     clk, resetn          clock / asynchronous active-low reset
//     push_i, push_*_i     write one entry (caller guarantees !full_o)
//     pop_i                drop head entry (caller guarantees !empty_o)
//     head_addr_o/data_o   current head entry
//     full_o, empty_o      occupancy flags
//     ent_valid_o          per-slot valid mask (physical slot order)
//     ent_addr_o           per-slot address taps for hazard compare
//   DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module wb_lu_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned AW    = 5,
    parameter int unsigned DW    = 32
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      push_i,
    input  logic [AW-1:0]             push_addr_i,
    input  logic [DW-1:0]             push_data_i,
    input  logic                      pop_i,
    output logic [AW-1:0]             head_addr_o,
    output logic [DW-1:0]             head_data_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic [DEPTH-1:0]          ent_valid_o,
    output logic [DEPTH-1:0][AW-1:0]  ent_addr_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [AW-1:0] addr_mem_q [DEPTH];
    logic [DW-1:0] data_mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic [PW-1:0] off;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (push_i && !pop_i) count_d = count_q + CW'(1);
        if (pop_i && !push_i) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; validity is tracked solely by count_q.
    always_ff @(posedge clk) begin
        if (push_i) begin
            addr_mem_q[wr_ptr_q] <= push_addr_i;
            data_mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_addr_o = addr_mem_q[rd_ptr_q];
    assign head_data_o = data_mem_q[rd_ptr_q];
    assign full_o      = (count_q == CW'(DEPTH));
    assign empty_o     = (count_q == '0);

    // A slot is live when its distance from the read pointer is below count.
    always_comb begin
        off         = '0;
        ent_valid_o = '0;
        ent_addr_o  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            off            = PW'(i) - rd_ptr_q;
            ent_valid_o[i] = (CW'(off) < count_q);
            ent_addr_o[i]  = addr_mem_q[i];
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter
//   Owns the regfile write port and shares it between the in-order pipeline
//   writeback and a late-result unit (MUL/DIV, missed loads). Late results
//   are buffered and drained into idle pipeline slots; a head entry denied
//   STARVE_MAX cycles forces a one-cycle pipeline stall to drain it.
//   Ports:
//     clk, resetn                     clock / asynchronous active-low reset
//     pipe_we/_waddr/_wdata           pipeline writeback request
//     pipe_stall                      holds WB/MEM; pipe_we ignored while high
//     lu_valid/_waddr/_wdata,lu_ready late-result valid/ready handshake
//     q_addr, q_hit                   RAW query against pending late results
//     rf_we/_waddr/_wdata             registered regfile write port
//     stat_force_cnt                  forced-stall counter (WB_ARB_STATS_EN)
//   Build option: define WB_ARB_STATS_EN to enable the saturating counter;
//   otherwise stat_force_cnt reads as zero.
// ---------------------------------------------------------------------------
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W     = DEFAULT_DATA_W,
    parameter int unsigned ADDR_W     = DEFAULT_ADDR_W,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              pipe_we,
    input  logic [ADDR_W-1:0] pipe_waddr,
    input  logic [DATA_W-1:0] pipe_wdata,
    output logic              pipe_stall,
    input  logic              lu_valid,
    output logic              lu_ready,
    input  logic [ADDR_W-1:0] lu_waddr,
    input  logic [DATA_W-1:0] lu_wdata,
    input  logic [ADDR_W-1:0] q_addr,
    output logic              q_hit,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [15:0]       stat_force_cnt
);

    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    logic                             fifo_full, fifo_empty, push, pop;
    logic [ADDR_W-1:0]                head_addr;
    logic [DATA_W-1:0]                head_data;
    logic [FIFO_DEPTH-1:0]            ent_valid;
    logic [FIFO_DEPTH-1:0][ADDR_W-1:0] ent_addr;

    arb_state_e        state_q, state_d;
    logic [SW-1:0]     starve_q, starve_d;
    gnt_src_e          gnt_src;
    logic [ADDR_W-1:0] gnt_addr;
    logic [DATA_W-1:0] gnt_data;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

    assign lu_ready = !fifo_full;
    assign push     = lu_valid && !fifo_full;

    wb_lu_fifo #(
        .DEPTH (FIFO_DEPTH),
        .AW    (ADDR_W),
        .DW    (DATA_W)
    ) u_fifo (
        .clk         (clk),
        .resetn      (resetn),
        .push_i      (push),
        .push_addr_i (lu_waddr),
        .push_data_i (lu_wdata),
        .pop_i       (pop),
        .head_addr_o (head_addr),
        .head_data_o (head_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .ent_valid_o (ent_valid),
        .ent_addr_o  (ent_addr)
    );

    always_comb begin
        pipe_stall = 1'b0;
        pop        = 1'b0;
        gnt_src    = GNT_NONE;
        starve_d   = starve_q;
        state_d    = ARB_NORMAL;

        if (state_q == ARB_FORCE) begin
            pipe_stall = 1'b1;
            pop        = 1'b1;
            gnt_src    = GNT_HEAD;
        end else if (pipe_we) begin
            gnt_src    = GNT_PIPE;
        end else if (!fifo_empty) begin
            pop        = 1'b1;
            gnt_src    = GNT_HEAD;
        end

        // Count denied cycles of a waiting head; the force state is entered
        // on the cycle the count reaches STARVE_MAX and lasts one pop.
        if (pop || fifo_empty) starve_d = '0;
        else                   starve_d = starve_q + SW'(1);
        if (starve_d == SW'(STARVE_MAX)) state_d = ARB_FORCE;
    end

    always_comb begin
        gnt_addr = '0;
        gnt_data = '0;
        case (gnt_src)
            GNT_PIPE: begin gnt_addr = pipe_waddr; gnt_data = pipe_wdata; end
            GNT_HEAD: begin gnt_addr = head_addr;  gnt_data = head_data;  end
            default:  ;
        endcase
        rf_we_d    = (gnt_src != GNT_NONE) && (gnt_addr != ADDR_W'(REG_ZERO));
        rf_waddr_d = gnt_addr;
        rf_wdata_d = gnt_data;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ARB_NORMAL;
            starve_q   <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

    always_comb begin
        q_hit = 1'b0;
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            if (ent_valid[i] && (ent_addr[i] == q_addr) && (q_addr != ADDR_W'(REG_ZERO)))
                q_hit = 1'b1;
        end
    end

`ifdef WB_ARB_STATS_EN
    logic [15:0] stat_q;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            stat_q <= '0;
        else if (state_q == ARB_FORCE && stat_q != '1)
            stat_q <= stat_q + 16'd1;
    end
    assign stat_force_cnt = stat_q;
`else
    assign stat_force_cnt = '0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_port_arbiter
//   Self-checking bench for wb_port_arbiter: directed scenarios plus a
//   randomized run against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_wb_port_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 2;
    localparam int SMAX  = 4;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          pipe_we = 1'b0;
    logic [AW-1:0] pipe_waddr = '0;
    logic [DW-1:0] pipe_wdata = '0;
    logic          lu_valid = 1'b0;
    logic [AW-1:0] lu_waddr = '0;
    logic [DW-1:0] lu_wdata = '0;
    logic [AW-1:0] q_addr = '0;
    logic          pipe_stall, lu_ready, q_hit, rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [15:0]   stat_force_cnt;

    always #5 clk = ~clk;

    wb_port_arbiter #(
        .DATA_W     (DW),
        .ADDR_W     (AW),
        .FIFO_DEPTH (DEPTH),
        .STARVE_MAX (SMAX)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .pipe_we        (pipe_we),
        .pipe_waddr     (pipe_waddr),
        .pipe_wdata     (pipe_wdata),
        .pipe_stall     (pipe_stall),
        .lu_valid       (lu_valid),
        .lu_ready       (lu_ready),
        .lu_waddr       (lu_waddr),
        .lu_wdata       (lu_wdata),
        .q_addr         (q_addr),
        .q_hit          (q_hit),
        .rf_we          (rf_we),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .stat_force_cnt (stat_force_cnt)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } ent_t;

    // Reference model: pending late results in acceptance order, how long
    // the head has waited, and whether the next cycle is a forced drain.
    ent_t          mq[$];
    int            m_wait;
    bit            m_force;
    int            m_stat;
    bit            e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;

    task automatic model_reset();
        mq.delete();
        m_wait  = 0;
        m_force = 0;
        m_stat  = 0;
        e_we    = 0;
        e_addr  = '0;
        e_data  = '0;
    endtask

    task automatic model_edge();
        bit            g = 0;
        bit            took = 0;
        bit            was_full;
        bit            was_empty;
        logic [AW-1:0] a = '0;
        logic [DW-1:0] d = '0;
        ent_t          e;
        was_full  = (mq.size() == DEPTH);
        was_empty = (mq.size() == 0);
        if (m_force) begin
            g = 1; took = 1; a = mq[0].a; d = mq[0].d;
            if (m_stat < 65535) m_stat++;
        end else if (pipe_we) begin
            g = 1; a = pipe_waddr; d = pipe_wdata;
        end else if (!was_empty) begin
            g = 1; took = 1; a = mq[0].a; d = mq[0].d;
        end
        e_we   = g && (a != 0);
        e_addr = a;
        e_data = d;
        if (took || was_empty) m_wait = 0;
        else                   m_wait++;
        m_force = (m_wait == SMAX);
        if (took) void'(mq.pop_front());
        if (lu_valid && !was_full) begin
            e.a = lu_waddr; e.d = lu_wdata;
            mq.push_back(e);
        end
    endtask

    function automatic bit mdl_qhit(logic [AW-1:0] qa);
        if (qa == 0) return 0;
        foreach (mq[i]) if (mq[i].a == qa) return 1;
        return 0;
    endfunction

    function automatic logic [15:0] exp_stat();
`ifdef WB_ARB_STATS_EN
        return 16'(m_stat);
`else
        return 16'd0;
`endif
    endfunction

    task automatic tick();
        @(negedge clk);
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_rf_we: got %0d exp 0", rf_we); end
        n_cmp++; if (rf_waddr !== '0) begin n_fail++; $display("FAIL reset_rf_waddr: got %0d exp 0", rf_waddr); end
        n_cmp++; if (rf_wdata !== '0) begin n_fail++; $display("FAIL reset_rf_wdata: got %0h exp 0", rf_wdata); end
        n_cmp++; if (pipe_stall !== 1'b0) begin n_fail++; $display("FAIL reset_pipe_stall: got %0d exp 0", pipe_stall); end
        n_cmp++; if (lu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_lu_ready: got %0d exp 1", lu_ready); end
        n_cmp++; if (q_hit !== 1'b0) begin n_fail++; $display("FAIL reset_q_hit: got %0d exp 0", q_hit); end
        n_cmp++; if (stat_force_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_stat: got %0d exp 0", stat_force_cnt); end
        resetn = 1'b1;
        // Fill the FIFO while the pipeline keeps the port busy.
        pipe_we = 1; pipe_waddr = 5'd3; pipe_wdata = 32'h0303_0303;
        lu_valid = 1; lu_waddr = 5'd20; lu_wdata = 32'h2020_2020;
        tick();
        lu_waddr = 5'd21; lu_wdata = 32'h2121_2121;
        tick();
        lu_valid = 0; q_addr = 5'd20;
        #1;
        n_cmp++; if (q_hit !== 1'b1) begin n_fail++; $display("FAIL rst_pre_q_hit: got %0d exp 1", q_hit); end
        n_cmp++; if (lu_ready !== 1'b0) begin n_fail++; $display("FAIL rst_pre_full: got %0d exp 0", lu_ready); end
        n_cmp++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL rst_pre_rf_we: got %0d exp 1", rf_we); end
        resetn = 1'b0;
        #1;
        n_cmp++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL rst_mid_rf_we: got %0d exp 0", rf_we); end
        n_cmp++; if (lu_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_lu_ready: got %0d exp 1", lu_ready); end
        n_cmp++; if (q_hit !== 1'b0) begin n_fail++; $display("FAIL rst_mid_q_hit: got %0d exp 0", q_hit); end
        model_reset();
        pipe_we = 0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_cmp++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL rst_post_rf_we[%0d]: got %0d exp 0", i, rf_we); end
        end
        #1;
        n_cmp++; if (q_hit !== 1'b0) begin n_fail++; $display("FAIL rst_post_q_hit: got %0d exp 0", q_hit); end
    endtask

    task automatic test_idle_drain();
        pipe_we = 0; lu_valid = 1; lu_waddr = 5'd8; lu_wdata = 32'hDEAD_BEEF; q_addr = 5'd8;
        #1;
        n_cmp++; if (lu_ready !== 1'b1) begin n_fail++; $display("FAIL drain_lu_ready: got %0d exp 1", lu_ready); end
        tick();
        n_cmp++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL drain_early: got %0d exp 0", rf_we); end
        lu_valid = 0;
        #1;
        n_cmp++; if (q_hit !== 1'b1) begin n_fail++; $display("FAIL drain_q_hit: got %0d exp 1", q_hit); end
        tick();
        n_cmp++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL drain_rf_we: got %0d exp 1", rf_we); end
        n_cmp++; if (rf_waddr !== 5'd8) begin n_fail++; $display("FAIL drain_rf_waddr: got %0d exp 8", rf_waddr); end
        n_cmp++; if (rf_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL drain_rf_wdata: got %0h exp deadbeef", rf_wdata); end
        tick();
        n_cmp++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL drain_held: got %0d exp 0", rf_we); end
    endtask

    task automatic test_priority();
        pipe_we = 1; pipe_waddr = 5'd3; pipe_wdata = 32'h3333_0000;
        lu_valid = 1; lu_waddr = 5'd9; lu_wdata = 32'h9999_9999;
        tick();
        lu_valid = 0;
        n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3) begin n_fail++; $display("FAIL prio_c0: got we=%0d a=%0d exp we=1 a=3", rf_we, rf_waddr); end
        for (int k = 1; k <= SMAX; k++) begin
            pipe_wdata = 32'h3333_0000 + 32'(k);
            #1;
            n_cmp++; if (pipe_stall !== 1'b0) begin n_fail++; $display("FAIL prio_stall_c%0d: got %0d exp 0", k, pipe_stall); end
            tick();
            n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3) begin n_fail++; $display("FAIL prio_pipe_c%0d: got we=%0d a=%0d exp we=1 a=3", k, rf_we, rf_waddr); end
        end
        #1;
        n_cmp++; if (pipe_stall !== 1'b1) begin n_fail++; $display("FAIL prio_force_stall: got %0d exp 1", pipe_stall); end
        tick();
        n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'h9999_9999) begin n_fail++; $display("FAIL prio_forced_write: got we=%0d a=%0d d=%0h exp we=1 a=9 d=99999999", rf_we, rf_waddr, rf_wdata); end
        #1;
        n_cmp++; if (pipe_stall !== 1'b0) begin n_fail++; $display("FAIL prio_stall_release: got %0d exp 0", pipe_stall); end
        tick();
        n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3) begin n_fail++; $display("FAIL prio_resume: got we=%0d a=%0d exp we=1 a=3", rf_we, rf_waddr); end
        pipe_we = 0;
        tick();
    endtask

    task automatic test_full_fifo();
        ent_t acc[$];
        ent_t got[$];
        ent_t e;
        int   nxt = 0;
        bit   accept;
        pipe_we = 1; pipe_waddr = 5'd3;
        lu_valid = 1; lu_waddr = 5'd16; lu_wdata = $urandom;
        for (int c = 0; c < 28; c++) begin
            pipe_wdata = $urandom;
            #1;
            accept = (mq.size() < DEPTH);
            if (c < 3) begin
                n_cmp++; if (lu_ready !== (c < 2)) begin n_fail++; $display("FAIL full_ready_c%0d: got %0d exp %0d", c, lu_ready, (c < 2)); end
            end
            if (accept) begin e.a = lu_waddr; e.d = lu_wdata; acc.push_back(e); end
            tick();
            if (rf_we && rf_waddr != 5'd3) begin e.a = rf_waddr; e.d = rf_wdata; got.push_back(e); end
            if (accept) begin nxt++; lu_waddr = AW'(16 + nxt); lu_wdata = $urandom; end
        end
        pipe_we = 0; lu_valid = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (rf_we && rf_waddr != 5'd3) begin e.a = rf_waddr; e.d = rf_wdata; got.push_back(e); end
        end
        n_cmp++; if (got.size() !== acc.size()) begin n_fail++; $display("FAIL full_count: got %0d exp %0d", got.size(), acc.size()); end
        for (int i = 0; i < acc.size() && i < got.size(); i++) begin
            n_cmp++; if (got[i].a !== acc[i].a || got[i].d !== acc[i].d) begin n_fail++; $display("FAIL full_order[%0d]: got %0d/%0h exp %0d/%0h", i, got[i].a, got[i].d, acc[i].a, acc[i].d); end
        end
        #1;
        n_cmp++; if (lu_ready !== 1'b1) begin n_fail++; $display("FAIL full_drained: got %0d exp 1", lu_ready); end
    endtask

    task automatic test_zero_reg();
        pipe_we = 1; pipe_waddr = 5'd0; pipe_wdata = 32'h1111_1111;
        lu_valid = 1; lu_waddr = 5'd0; lu_wdata = 32'h0000_0005;
        tick();
        n_cmp++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL zero_pipe: got %0d exp 0", rf_we); end
        pipe_we = 0; lu_valid = 0;
        tick();
        n_cmp++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL zero_lu: got %0d exp 0", rf_we); end
        #1;
        n_cmp++; if (lu_ready !== 1'b1) begin n_fail++; $display("FAIL zero_lu_ready: got %0d exp 1", lu_ready); end
        lu_valid = 1; lu_waddr = 5'd7; lu_wdata = 32'h7777_0007;
        tick();
        lu_valid = 0;
        n_cmp++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL zero_next_push: got %0d exp 0", rf_we); end
        tick();
        n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h7777_0007) begin n_fail++; $display("FAIL zero_popped: got we=%0d a=%0d d=%0h exp we=1 a=7 d=77770007", rf_we, rf_waddr, rf_wdata); end
        tick();
    endtask

    task automatic test_hazard_query();
        pipe_we = 1; pipe_waddr = 5'd3; pipe_wdata = 32'h0000_0033;
        lu_valid = 1; lu_waddr = 5'd12; lu_wdata = 32'h1212_1212;
        tick();
        lu_valid = 0; q_addr = 5'd12;
        #1;
        n_cmp++; if (q_hit !== 1'b1) begin n_fail++; $display("FAIL hq_r12: got %0d exp 1", q_hit); end
        q_addr = 5'd0;
        #1;
        n_cmp++; if (q_hit !== 1'b0) begin n_fail++; $display("FAIL hq_r0: got %0d exp 0", q_hit); end
        q_addr = 5'd13;
        #1;
        n_cmp++; if (q_hit !== 1'b0) begin n_fail++; $display("FAIL hq_r13: got %0d exp 0", q_hit); end
        q_addr = 5'd12; pipe_we = 0;
        tick();
        n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== 5'd12) begin n_fail++; $display("FAIL hq_pop: got we=%0d a=%0d exp we=1 a=12", rf_we, rf_waddr); end
        #1;
        n_cmp++; if (q_hit !== 1'b0) begin n_fail++; $display("FAIL hq_after_pop: got %0d exp 0", q_hit); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            pipe_we    = ($urandom_range(0, 99) < 65);
            pipe_waddr = AW'($urandom_range(0, 31));
            pipe_wdata = $urandom;
            lu_valid   = ($urandom_range(0, 99) < 45);
            lu_waddr   = AW'($urandom_range(0, 31));
            lu_wdata   = $urandom;
            if (mq.size() > 0 && $urandom_range(0, 1) == 1)
                q_addr = mq[$urandom_range(0, mq.size() - 1)].a;
            else
                q_addr = AW'($urandom_range(0, 31));
            #1;
            n_cmp++; if (lu_ready !== (mq.size() < DEPTH)) begin n_fail++; $display("FAIL rnd_lu_ready c%0d: got %0d exp %0d", c, lu_ready, (mq.size() < DEPTH)); end
            n_cmp++; if (pipe_stall !== m_force) begin n_fail++; $display("FAIL rnd_pipe_stall c%0d: got %0d exp %0d", c, pipe_stall, m_force); end
            n_cmp++; if (q_hit !== mdl_qhit(q_addr)) begin n_fail++; $display("FAIL rnd_q_hit c%0d: got %0d exp %0d", c, q_hit, mdl_qhit(q_addr)); end
            n_cmp++; if (stat_force_cnt !== exp_stat()) begin n_fail++; $display("FAIL rnd_stat c%0d: got %0d exp %0d", c, stat_force_cnt, exp_stat()); end
            tick();
            n_cmp++; if (rf_we !== e_we) begin n_fail++; $display("FAIL rnd_rf_we c%0d: got %0d exp %0d", c, rf_we, e_we); end
            if (e_we) begin
                n_cmp++; if (rf_waddr !== e_addr || rf_wdata !== e_data) begin n_fail++; $display("FAIL rnd_rf_data c%0d: got %0d/%0h exp %0d/%0h", c, rf_waddr, rf_wdata, e_addr, e_data); end
            end
        end
        pipe_we = 0; lu_valid = 0;
        repeat (4) tick();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_idle_drain();
        test_priority();
        test_full_fifo();
        test_zero_reg();
        test_hazard_query();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
